// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_cell.sv
// One-digit BCD add with nine's-complement operand select for subtraction.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               sub,
    input  logic               k,
    output logic [DIGIT_W-1:0] s_d,
    output logic               k_out,
    output logic               bad
);

    logic [DIGIT_W-1:0] b_sel;
    logic [DIGIT_W:0]   t;

    always_comb begin
        b_sel = sub ? (BCD_MAX - b_d) : b_d;
        t     = {1'b0, a_d} + {1'b0, b_sel} + {{DIGIT_W{1'b0}}, k};
        k_out = (t > {1'b0, BCD_MAX});
        // (t + 6) mod 16 only needs the low nibble of t
        s_d   = k_out ? (t[DIGIT_W-1:0] + BCD_CORR) : t[DIGIT_W-1:0];
        bad   = (a_d > BCD_MAX) || (b_d > BCD_MAX);
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial multi-digit BCD adder/subtractor, LSD first, valid/ready on both sides.
module bcd_addsub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DIGITS-1:0]     s,
    output logic                    c,
    output logic                    err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             sub_q, sub_d;
    logic             k_q, k_d;
    logic             err_q, err_d;

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_k;
    logic               dig_bad;
    logic [W-1:0]       sum_shift;

    bcd_digit_cell u_cell (
        .a_d   (opa_q[DIGIT_W-1:0]),
        .b_d   (opb_q[DIGIT_W-1:0]),
        .sub   (sub_q),
        .k     (k_q),
        .s_d   (dig_s),
        .k_out (dig_k),
        .bad   (dig_bad)
    );

    // New digits enter at the MSD end so the result is aligned after DIGITS shifts
    generate
        if (DIGITS == 1) begin : g_one
            assign sum_shift = dig_s;
        end else begin : g_many
            assign sum_shift = {dig_s, sum_q[W-1:DIGIT_W]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        sub_d   = sub_q;
        k_d     = k_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    sub_d   = sub;
                    k_d     = sub ? ~cin : cin;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                opa_d = opa_q >> DIGIT_W;
                opb_d = opb_q >> DIGIT_W;
                sum_d = sum_shift;
                k_d   = dig_k;
                err_d = err_q | dig_bad;
                idx_d = idx_q + CNT_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            k_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            sub_q   <= sub_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign s         = sum_q;
    assign c         = k_q;
    assign err       = err_q;

endmodule
